st_stream_fifo_mon: RTL and testbench

- Parametrised Avalon-ST buffering stage placed after the mSGDMA streaming source (data/valid/ready) in the FPGA fabric.
- Decouples the DMA source from a downstream consumer through a first-word-fall-through FIFO.
- Accumulates a running word count and an additive checksum of the accepted stream.
- Drives a 4-bit status vector intended for the fpga_led_pio export / board LEDs.

---
 rtl/st_stream_fifo_mon_if.sv | 11 +
 rtl/st_stream_fifo_mon.sv | 108 ++++++++++
 tb/tb_st_stream_fifo_mon.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/st_stream_fifo_mon_if.sv
// rtl/st_stream_fifo_mon_if.sv - data/valid/ready stream bundle for st_stream_fifo_mon
interface st_stream_fifo_mon_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/st_stream_fifo_mon.sv
// rtl/st_stream_fifo_mon.sv - FWFT stream FIFO with word count, checksum and LED status
// Sits between the mSGDMA stream source and a downstream consumer.
module st_stream_fifo_mon #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 16,
  parameter int AFULL_TH = 14,
  parameter int HB_DIV   = 26
) (
  input  logic                    clk_100_clk,
  input  logic                    reset_reset_n,
  st_stream_fifo_mon_if.slave     snk,
  st_stream_fifo_mon_if.master    src,
  input  logic                    clr,
  output logic [31:0]             word_count,
  output logic [DATA_W-1:0]       checksum,
  output logic [$clog2(DEPTH):0]  fill_level,
  output logic                    almost_full,
  output logic [3:0]              led_export
);
  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;
  localparam logic [FW-1:0] DEPTH_F = FW'(DEPTH);
  localparam logic [FW-1:0] AFULL_F = FW'(AFULL_TH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [FW-1:0]     fill;
  logic [FW-1:0]     fill_next;
  logic              snk_ready_q;
  logic              not_empty;
  logic              push;
  logic              pop;
  logic              stall_q;
  logic              hb_q;
  logic [1:0]        led_lo_q;
  logic [HB_DIV-1:0] hb_cnt;

  assign not_empty = (fill != '0);
  assign push      = snk.valid && snk_ready_q;
  assign pop       = not_empty && src.ready;

  always_comb begin
    fill_next = fill;
    case ({push, pop})
      2'b10:   fill_next = fill + FW'(1);
      2'b01:   fill_next = fill - FW'(1);
      default: fill_next = fill;
    endcase
  end

  always_ff @(posedge clk_100_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fill        <= '0;
      snk_ready_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      fill        <= fill_next;
      snk_ready_q <= (fill_next < DEPTH_F);
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk_100_clk) begin
    if (push) mem[wr_ptr] <= snk.data;
  end

  // clr wins over a same-cycle push so the statistics restart from a clean zero.
  always_ff @(posedge clk_100_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      word_count <= '0;
      checksum   <= '0;
      stall_q    <= 1'b0;
    end else if (clr) begin
      word_count <= '0;
      checksum   <= '0;
      stall_q    <= 1'b0;
    end else begin
      if (push) begin
        if (word_count != 32'hFFFF_FFFF) word_count <= word_count + 32'd1;
        checksum <= checksum + snk.data;
      end
      if (snk.valid && !snk_ready_q) stall_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_100_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      hb_cnt   <= '0;
      hb_q     <= 1'b0;
      led_lo_q <= 2'b00;
    end else begin
      hb_cnt   <= hb_cnt + HB_DIV'(1);
      if (&hb_cnt) hb_q <= ~hb_q;
      led_lo_q <= {almost_full, not_empty};
    end
  end

  assign snk.ready   = snk_ready_q;
  assign src.valid   = not_empty;
  assign src.data    = not_empty ? mem[rd_ptr] : '0;
  assign fill_level  = fill;
  assign almost_full = (fill >= AFULL_F);
  assign led_export  = {hb_q, stall_q, led_lo_q};
endmodule

// File: tb/tb_st_stream_fifo_mon.sv
// tb/tb_st_stream_fifo_mon.sv - self-checking bench for st_stream_fifo_mon
module tb_st_stream_fifo_mon;
  localparam int DATA_W   = 32;
  localparam int DEPTH    = 16;
  localparam int AFULL_TH = 14;
  localparam int HB_DIV   = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              clr = 1'b0;
  logic [31:0]       word_count;
  logic [DATA_W-1:0] checksum;
  logic [4:0]        fill_level;
  logic              almost_full;
  logic [3:0]        led_export;

  st_stream_fifo_mon_if #(.DATA_W(DATA_W)) snk ();
  st_stream_fifo_mon_if #(.DATA_W(DATA_W)) src ();

  always #5 clk = ~clk;

  st_stream_fifo_mon #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .AFULL_TH(AFULL_TH), .HB_DIV(HB_DIV)
  ) dut (
    .clk_100_clk(clk),
    .reset_reset_n(rst_n),
    .snk(snk),
    .src(src),
    .clr(clr),
    .word_count(word_count),
    .checksum(checksum),
    .fill_level(fill_level),
    .almost_full(almost_full),
    .led_export(led_export)
  );

  // Reference model: a queue plus plain counters
  logic [DATA_W-1:0] q[$];
  bit                m_ready;
  longint            m_wc;
  logic [DATA_W-1:0] m_cks;
  bit                m_stall;
  bit [1:0]          m_led01;
  int                m_edges;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    bit          v;
    logic [31:0] d;
    bit          r;
    int          e_fill;
    bit          e_ready;
    logic [31:0] e_data;
    logic [31:0] e_wc;
    logic [31:0] e_cks;
    bit          e_af;
  } vec_t;
  vec_t tbl[33];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ready = 0; m_wc = 0; m_cks = '0; m_stall = 0; m_led01 = 2'b00; m_edges = 0;
  endtask

  task automatic model_edge(input bit v, input logic [31:0] d, input bit r, input bit c);
    bit push;
    bit pop;
    push = v && m_ready;
    pop  = r && (q.size() != 0);
    m_led01 = {q.size() >= AFULL_TH, q.size() != 0};
    if (c) begin
      m_wc = 0; m_cks = '0; m_stall = 0;
    end else begin
      if (v && !m_ready) m_stall = 1;
      if (push) begin
        if (m_wc < 64'hFFFF_FFFF) m_wc++;
        m_cks = m_cks + d;
      end
    end
    if (pop) void'(q.pop_front());
    if (push) q.push_back(d);
    m_ready = (q.size() < DEPTH);
    m_edges++;
  endtask

  task automatic check_all(input string tag);
    logic [31:0] head;
    bit          hb;
    head = (q.size() != 0) ? q[0] : '0;
    hb   = ((m_edges >> HB_DIV) & 1) != 0;
    chk({tag, ".snk_ready"}, snk.ready, m_ready);
    chk({tag, ".src_valid"}, src.valid, q.size() != 0);
    chk({tag, ".src_data"}, src.data, head);
    chk({tag, ".fill"}, fill_level, q.size());
    chk({tag, ".almost_full"}, almost_full, q.size() >= AFULL_TH);
    chk({tag, ".word_count"}, word_count, m_wc);
    chk({tag, ".checksum"}, checksum, m_cks);
    chk({tag, ".led"}, led_export, {hb, m_stall, m_led01});
  endtask

  task automatic cycle(input bit v, input logic [31:0] d, input bit r, input bit c, input string tag);
    snk.valid = v; snk.data = d; src.ready = r; clr = c;
    @(posedge clk);
    model_edge(v, d, r, c);
    #1;
    check_all(tag);
  endtask

  initial begin
    int     k;
    longint sum;
    snk.valid = 0; snk.data = '0; src.ready = 0; clr = 0;
    model_reset();

    // Table: fill 1..16 with consumer stalled, one blocked attempt, then drain
    sum = 0;
    for (int i = 0; i < 16; i++) begin
      sum += i + 1;
      tbl[i] = '{v: 1, d: i + 1, r: 0, e_fill: i + 1, e_ready: (i + 1) < 16,
                 e_data: 1, e_wc: i + 1, e_cks: sum, e_af: (i + 1) >= 14};
    end
    tbl[16] = '{v: 1, d: 32'h99, r: 0, e_fill: 16, e_ready: 0, e_data: 1,
                e_wc: 16, e_cks: 32'h88, e_af: 1};
    for (int j = 1; j <= 16; j++)
      tbl[16 + j] = '{v: 0, d: 0, r: 1, e_fill: 16 - j, e_ready: 1,
                      e_data: (j < 16) ? j + 1 : 0, e_wc: 16, e_cks: 32'h88,
                      e_af: (16 - j) >= 14};

    repeat (2) @(posedge clk);
    #1;
    check_all("in_reset");
    rst_n = 1;

    cycle(0, '0, 0, 0, "release");
    chk("release.snk_ready_c1", snk.ready, 1'b1);
    chk("release.led", led_export, 4'b0000);

    for (int i = 0; i < 33; i++) begin
      string t;
      t = $sformatf("tbl%0d", i);
      cycle(tbl[i].v, tbl[i].d, tbl[i].r, 0, t);
      chk({t, ".fill_t"}, fill_level, tbl[i].e_fill);
      chk({t, ".ready_t"}, snk.ready, tbl[i].e_ready);
      chk({t, ".valid_t"}, src.valid, tbl[i].e_fill != 0);
      chk({t, ".data_t"}, src.data, tbl[i].e_data);
      chk({t, ".wc_t"}, word_count, tbl[i].e_wc);
      chk({t, ".cks_t"}, checksum, tbl[i].e_cks);
      chk({t, ".af_t"}, almost_full, tbl[i].e_af);
      if (i == 16) chk("stall_led", led_export[2], 1'b1);
    end

    // Streaming: 100 cycles with valid and ready both held high
    cycle(0, '0, 0, 1, "clr0");
    chk("clr0.wc", word_count, 32'd0);
    for (int i = 0; i < 100; i++) begin
      cycle(1, 32'h1000 + i, 1, 0, "stream");
      chk("stream.fill1", fill_level, 5'd1);
      chk("stream.data", src.data, 32'h1000 + i);
    end
    chk("stream.wc100", word_count, 32'd100);
    cycle(0, '0, 1, 0, "stream_end");

    // Checksum wrap, then clr keeps FIFO occupancy
    cycle(0, '0, 0, 1, "clr1");
    cycle(1, 32'hFFFF_FFFF, 0, 0, "wrap_a");
    cycle(1, 32'hFFFF_FFFF, 0, 0, "wrap_b");
    chk("wrap.cks", checksum, 32'hFFFF_FFFE);
    cycle(1, 32'h5, 0, 1, "clr_push");
    chk("clr_push.wc", word_count, 32'd0);
    chk("clr_push.cks", checksum, 32'd0);
    chk("clr_push.stall", led_export[2], 1'b0);
    chk("clr_push.fill", fill_level, 5'd3);

    // Randomized traffic in blocks with varied consumer pressure
    for (int b = 0; b < 8; b++) begin
      int pr;
      pr = (b % 4) + 1;
      for (int i = 0; i < 50; i++)
        cycle(($urandom % 4) != 0, $urandom, ($urandom % 5) < pr,
              ($urandom % 40) == 0, "rand");
    end

    // Reset asserted with 5 words buffered
    k = 0;
    while (q.size() != 0 && k < 40) begin
      cycle(0, '0, 1, 0, "drain");
      k++;
    end
    chk("drain.bound", q.size(), 0);
    for (int i = 0; i < 5; i++) cycle(1, 32'h200 + i, 0, 0, "pre_rst");
    chk("pre_rst.fill", fill_level, 5'd5);
    #2;
    rst_n = 0;
    model_reset();
    #1;
    chk("rst_mid.src_valid", src.valid, 1'b0);
    chk("rst_mid.fill", fill_level, 5'd0);
    check_all("rst_mid");
    @(negedge clk);
    rst_n = 1;
    cycle(0, '0, 0, 0, "post_rst");
    chk("post_rst.valid", src.valid, 1'b0);
    cycle(1, 32'hA5A5_A5A5, 0, 0, "a5");
    chk("a5.valid", src.valid, 1'b1);
    chk("a5.data", src.data, 32'hA5A5_A5A5);
    for (int i = 0; i < 40; i++) cycle(0, '0, 1, 0, "hb");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
